// File: rtl/ps2_pkg.sv
// Shared types, constants and byte classifiers for the PS/2 scan-code receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_t;

    typedef enum logic [2:0] {
        P_IDLE = 3'd0,
        P_E0   = 3'd1,
        P_F0   = 3'd2,
        P_E0F0 = 3'd3,
        P_E1   = 3'd4
    } prefix_state_t;

    localparam logic [7:0]  PS2_E0      = 8'hE0;
    localparam logic [7:0]  PS2_F0      = 8'hF0;
    localparam logic [7:0]  PS2_E1      = 8'hE1;
    localparam logic [15:0] PS2_PAUSE   = 16'hE177;
    localparam logic [2:0]  PS2_E1_SKIP = 3'd7;

    // Device responses (BAT ok, echo, ack, failures, resend) that carry no key event.
    function automatic logic is_silent_drop(input logic [7:0] b);
        case (b)
            8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE: is_silent_drop = 1'b1;
            default:                                  is_silent_drop = 1'b0;
        endcase
    endfunction

    // Buffer overrun / key detection error codes from the keyboard.
    function automatic logic is_err_byte(input logic [7:0] b);
        case (b)
            8'h00, 8'hFF: is_err_byte = 1'b1;
            default:      is_err_byte = 1'b0;
        endcase
    endfunction

    // Odd parity over data plus parity bit: total count of ones must be odd.
    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        odd_parity_ok = ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: line synchroniser, clock glitch filter, frame FSM and
// inactivity timeout. Produces one byte per good frame or an error pulse.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 100000
)(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic [7:0] o_byte,
    output logic       o_byte_vld,
    output logic       o_frame_err
);

    localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic [FW-1:0] r_filt_cnt;
    logic          r_filt_clk, r_filt_clk_d;
    logic          w_fall;
    frame_state_t  r_state, w_state_nxt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_par_ok;
    logic [TW-1:0] r_to_cnt;
    logic          w_timeout, w_good, w_bad;

    // Two-flop synchronisers on both raw lines, idling high.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= i_ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= i_ps2_dat;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // Glitch filter: follow the synchronised clock only after FILT_LEN differing samples in a row.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_filt_cnt   <= '0;
            r_filt_clk   <= 1'b1;
            r_filt_clk_d <= 1'b1;
        end else begin
            r_filt_clk_d <= r_filt_clk;
            if (r_clk_s2 != r_filt_clk) begin
                if (r_filt_cnt == FW'(FILT_LEN - 1)) begin
                    r_filt_clk <= r_clk_s2;
                    r_filt_cnt <= '0;
                end else begin
                    r_filt_cnt <= r_filt_cnt + FW'(1);
                end
            end else begin
                r_filt_cnt <= '0;
            end
        end
    end

    assign w_fall    = r_filt_clk_d & ~r_filt_clk;
    // An edge in the terminal cycle keeps the frame alive.
    assign w_timeout = (r_state != IDLE) && !w_fall && (r_to_cnt == TW'(TIMEOUT_CYC - 1));

    // Frame FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame FSM next-state logic; a high start bit is simply ignored.
    always_comb begin
        w_state_nxt = r_state;
        if (w_timeout) begin
            w_state_nxt = IDLE;
        end else if (w_fall) begin
            case (r_state)
                IDLE: begin
                    if (r_dat_s2 == 1'b0) begin
                        w_state_nxt = DATA;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                DATA: begin
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = PARITY;
                    end else begin
                        w_state_nxt = DATA;
                    end
                end
                PARITY:  w_state_nxt = STOP;
                STOP:    w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Frame FSM outputs: judge the frame on the stop-bit edge.
    always_comb begin
        w_good = 1'b0;
        w_bad  = 1'b0;
        if (w_timeout) begin
            w_bad = 1'b1;
        end else if (w_fall && (r_state == STOP)) begin
            w_good = r_dat_s2 & r_par_ok;
            w_bad  = ~(r_dat_s2 & r_par_ok);
        end else begin
            w_good = 1'b0;
            w_bad  = 1'b0;
        end
    end

    // Datapath: bit shifting, parity capture, timeout counter and registered results.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'h00;
            r_par_ok    <= 1'b0;
            r_to_cnt    <= '0;
            o_byte      <= 8'h00;
            o_byte_vld  <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_byte_vld  <= w_good;
            o_frame_err <= w_bad;
            if (w_good) begin
                o_byte <= r_shift;
            end else begin
                o_byte <= o_byte;
            end
            if ((r_state == IDLE) || w_fall || w_timeout) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + TW'(1);
            end
            if (w_fall) begin
                case (r_state)
                    IDLE: r_bit_cnt <= 3'd0;
                    DATA: begin
                        r_shift   <= {r_dat_s2, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    PARITY:  r_par_ok <= odd_parity_ok(r_shift, r_dat_s2);
                    default: r_bit_cnt <= r_bit_cnt;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 scan-code receiver: collapses E0/F0/E1 prefix bytes into one 16-bit
// key code plus break flag per key event.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 100000
)(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ps2_clk,
    input  logic        i_ps2_dat,
    output logic [15:0] o_key,
    output logic        o_brk,
    output logic        o_vld,
    output logic        o_err
);

    logic [7:0]    w_byte;
    logic          w_byte_vld, w_frame_err;
    prefix_state_t r_pstate, w_pstate_nxt;
    logic [2:0]    r_skip, w_skip_nxt;
    logic          w_emit, w_emit_brk, w_drop_err;
    logic [15:0]   w_emit_key;

    ps2_frame_rx #(
        .FILT_LEN    (FILT_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_frame (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_ps2_clk   (i_ps2_clk),
        .i_ps2_dat   (i_ps2_dat),
        .o_byte      (w_byte),
        .o_byte_vld  (w_byte_vld),
        .o_frame_err (w_frame_err)
    );

    // Prefix FSM state register, including the pause-sequence skip counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pstate <= P_IDLE;
            r_skip   <= 3'd0;
        end else begin
            r_pstate <= w_pstate_nxt;
            r_skip   <= w_skip_nxt;
        end
    end

    // Prefix FSM next-state logic; a frame error abandons any partial sequence.
    always_comb begin
        w_pstate_nxt = r_pstate;
        w_skip_nxt   = r_skip;
        if (w_frame_err) begin
            w_pstate_nxt = P_IDLE;
            w_skip_nxt   = 3'd0;
        end else if (w_byte_vld) begin
            case (r_pstate)
                P_IDLE: begin
                    if (w_byte == PS2_E0) begin
                        w_pstate_nxt = P_E0;
                    end else if (w_byte == PS2_F0) begin
                        w_pstate_nxt = P_F0;
                    end else if (w_byte == PS2_E1) begin
                        w_pstate_nxt = P_E1;
                        w_skip_nxt   = PS2_E1_SKIP;
                    end else begin
                        w_pstate_nxt = P_IDLE;
                    end
                end
                P_E0: begin
                    if (w_byte == PS2_F0) begin
                        w_pstate_nxt = P_E0F0;
                    end else begin
                        w_pstate_nxt = P_IDLE;
                    end
                end
                P_F0, P_E0F0: w_pstate_nxt = P_IDLE;
                P_E1: begin
                    if (r_skip == 3'd1) begin
                        w_pstate_nxt = P_IDLE;
                        w_skip_nxt   = 3'd0;
                    end else begin
                        w_skip_nxt   = r_skip - 3'd1;
                    end
                end
                default: w_pstate_nxt = P_IDLE;
            endcase
        end else begin
            w_pstate_nxt = r_pstate;
        end
    end

    // Prefix FSM outputs: decide whether this byte completes a key event.
    always_comb begin
        w_emit     = 1'b0;
        w_emit_key = 16'h0000;
        w_emit_brk = 1'b0;
        w_drop_err = 1'b0;
        if (w_byte_vld && !w_frame_err) begin
            case (r_pstate)
                P_IDLE: begin
                    if ((w_byte == PS2_E0) || (w_byte == PS2_F0) || (w_byte == PS2_E1)) begin
                        w_emit = 1'b0;
                    end else if (is_err_byte(w_byte)) begin
                        w_drop_err = 1'b1;
                    end else if (is_silent_drop(w_byte)) begin
                        w_emit = 1'b0;
                    end else begin
                        w_emit     = 1'b1;
                        w_emit_key = {8'h00, w_byte};
                    end
                end
                P_E0: begin
                    if (w_byte == PS2_F0) begin
                        w_emit = 1'b0;
                    end else begin
                        w_emit     = 1'b1;
                        w_emit_key = {PS2_E0, w_byte};
                    end
                end
                P_F0: begin
                    w_emit     = 1'b1;
                    w_emit_key = {8'h00, w_byte};
                    w_emit_brk = 1'b1;
                end
                P_E0F0: begin
                    w_emit     = 1'b1;
                    w_emit_key = {PS2_E0, w_byte};
                    w_emit_brk = 1'b1;
                end
                P_E1: begin
                    if (r_skip == 3'd1) begin
                        w_emit     = 1'b1;
                        w_emit_key = PS2_PAUSE;
                    end else begin
                        w_emit = 1'b0;
                    end
                end
                default: w_emit = 1'b0;
            endcase
        end else begin
            w_emit = 1'b0;
        end
    end

    // Output registers: key/break hold between events, valid and error are single-cycle pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_key <= 16'h0000;
            o_brk <= 1'b0;
            o_vld <= 1'b0;
            o_err <= 1'b0;
        end else begin
            o_vld <= w_emit;
            o_err <= w_frame_err | w_drop_err;
            if (w_emit) begin
                o_key <= w_emit_key;
                o_brk <= w_emit_brk;
            end else begin
                o_key <= o_key;
                o_brk <= o_brk;
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed self-checking bench for ps2_scancode_rx.
module tb_ps2_scancode_rx;

    localparam int FILT_LEN    = 8;
    localparam int TIMEOUT_CYC = 400;
    localparam int HB          = 30;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_dat = 1'b1;
    logic [15:0] o_key;
    logic        o_brk, o_vld, o_err;

    int checks  = 0;
    int errors  = 0;
    int vld_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    ps2_scancode_rx #(
        .FILT_LEN    (FILT_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_ps2_clk (ps2_clk),
        .i_ps2_dat (ps2_dat),
        .o_key     (o_key),
        .o_brk     (o_brk),
        .o_vld     (o_vld),
        .o_err     (o_err)
    );

    // Count every cycle in which a pulse output is high.
    always @(negedge clk) begin
        if (o_vld) vld_cnt++;
        if (o_err) err_cnt++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        vld_cnt = 0;
        err_cnt = 0;
    endtask

    task automatic send_bit(input logic b);
        ps2_dat = b;
        wait_cyc(HB / 2);
        ps2_clk = 1'b0;
        wait_cyc(HB);
        ps2_clk = 1'b1;
        wait_cyc(HB / 2);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(bad_par ? (^b) : ~(^b));
        send_bit(1'b1);
        wait_cyc(HB);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_cyc(5);
        rst = 1'b0;
        clear_counts();
        wait_cyc(50);
        checks++; if (o_key !== 16'h0000) begin errors++; $display("FAIL reset_key: got %h expected %h", o_key, 16'h0000); end
        checks++; if (o_brk !== 1'b0) begin errors++; $display("FAIL reset_brk: got %b expected 0", o_brk); end
        checks++; if (vld_cnt != 0) begin errors++; $display("FAIL reset_vld: got %0d pulses expected 0", vld_cnt); end
        checks++; if (err_cnt != 0) begin errors++; $display("FAIL reset_err: got %0d pulses expected 0", err_cnt); end
    endtask

    task automatic test_make();
        clear_counts();
        send_byte(8'h1C, 1'b0);
        checks++; if (vld_cnt != 1) begin errors++; $display("FAIL make_vld: got %0d pulses expected 1", vld_cnt); end
        checks++; if (o_key !== 16'h001C) begin errors++; $display("FAIL make_key: got %h expected %h", o_key, 16'h001C); end
        checks++; if (o_brk !== 1'b0) begin errors++; $display("FAIL make_brk: got %b expected 0", o_brk); end
        checks++; if (err_cnt != 0) begin errors++; $display("FAIL make_err: got %0d pulses expected 0", err_cnt); end
        send_byte(8'h1C, 1'b0);
        checks++; if (vld_cnt != 2) begin errors++; $display("FAIL typematic_vld: got %0d pulses expected 2", vld_cnt); end
    endtask

    task automatic test_break();
        clear_counts();
        send_byte(8'hF0, 1'b0);
        checks++; if (vld_cnt != 0) begin errors++; $display("FAIL brk_prefix_vld: got %0d pulses expected 0", vld_cnt); end
        send_byte(8'h1C, 1'b0);
        checks++; if (vld_cnt != 1) begin errors++; $display("FAIL brk_vld: got %0d pulses expected 1", vld_cnt); end
        checks++; if (o_key !== 16'h001C) begin errors++; $display("FAIL brk_key: got %h expected %h", o_key, 16'h001C); end
        checks++; if (o_brk !== 1'b1) begin errors++; $display("FAIL brk_brk: got %b expected 1", o_brk); end
    endtask

    task automatic test_extended();
        clear_counts();
        send_byte(8'hE0, 1'b0);
        send_byte(8'h75, 1'b0);
        checks++; if (o_key !== 16'hE075) begin errors++; $display("FAIL ext_make_key: got %h expected %h", o_key, 16'hE075); end
        checks++; if (o_brk !== 1'b0) begin errors++; $display("FAIL ext_make_brk: got %b expected 0", o_brk); end
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h75, 1'b0);
        checks++; if (o_key !== 16'hE075) begin errors++; $display("FAIL ext_brk_key: got %h expected %h", o_key, 16'hE075); end
        checks++; if (o_brk !== 1'b1) begin errors++; $display("FAIL ext_brk_brk: got %b expected 1", o_brk); end
        checks++; if (vld_cnt != 2) begin errors++; $display("FAIL ext_vld: got %0d pulses expected 2", vld_cnt); end
    endtask

    task automatic test_parity_err();
        clear_counts();
        send_byte(8'hE0, 1'b0);
        send_byte(8'h1C, 1'b1);
        checks++; if (err_cnt != 1) begin errors++; $display("FAIL par_err: got %0d pulses expected 1", err_cnt); end
        checks++; if (vld_cnt != 0) begin errors++; $display("FAIL par_vld: got %0d pulses expected 0", vld_cnt); end
        send_byte(8'h1C, 1'b0);
        checks++; if (o_key !== 16'h001C) begin errors++; $display("FAIL par_clear_key: got %h expected %h", o_key, 16'h001C); end
        checks++; if (o_brk !== 1'b0) begin errors++; $display("FAIL par_clear_brk: got %b expected 0", o_brk); end
        checks++; if (vld_cnt != 1) begin errors++; $display("FAIL par_clear_vld: got %0d pulses expected 1", vld_cnt); end
    endtask

    task automatic test_drop();
        clear_counts();
        send_byte(8'hAA, 1'b0);
        send_byte(8'hFA, 1'b0);
        checks++; if ((vld_cnt != 0) || (err_cnt != 0)) begin errors++; $display("FAIL silent_drop: got vld=%0d err=%0d expected 0 0", vld_cnt, err_cnt); end
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        checks++; if (err_cnt != 2) begin errors++; $display("FAIL err_drop: got %0d pulses expected 2", err_cnt); end
        send_byte(8'h16, 1'b0);
        checks++; if (o_key !== 16'h0016) begin errors++; $display("FAIL drop_next_key: got %h expected %h", o_key, 16'h0016); end
        checks++; if (vld_cnt != 1) begin errors++; $display("FAIL drop_vld: got %0d pulses expected 1", vld_cnt); end
    endtask

    task automatic test_timeout();
        clear_counts();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        ps2_dat = 1'b1;
        wait_cyc(TIMEOUT_CYC + 10);
        checks++; if (err_cnt != 1) begin errors++; $display("FAIL timeout_err: got %0d pulses expected 1", err_cnt); end
        checks++; if (vld_cnt != 0) begin errors++; $display("FAIL timeout_vld: got %0d pulses expected 0", vld_cnt); end
        send_byte(8'h5A, 1'b0);
        checks++; if (o_key !== 16'h005A) begin errors++; $display("FAIL timeout_next_key: got %h expected %h", o_key, 16'h005A); end
        checks++; if (err_cnt != 1) begin errors++; $display("FAIL timeout_next_err: got %0d pulses expected 1", err_cnt); end
    endtask

    task automatic test_glitch();
        clear_counts();
        ps2_dat = 1'b0;
        wait_cyc(5);
        ps2_clk = 1'b0;
        wait_cyc(2);
        ps2_clk = 1'b1;
        wait_cyc(40);
        ps2_dat = 1'b1;
        wait_cyc(10);
        checks++; if ((vld_cnt != 0) || (err_cnt != 0)) begin errors++; $display("FAIL glitch_pulse: got vld=%0d err=%0d expected 0 0", vld_cnt, err_cnt); end
        checks++; if (o_key !== 16'h005A) begin errors++; $display("FAIL glitch_key: got %h expected %h", o_key, 16'h005A); end
        send_byte(8'h29, 1'b0);
        checks++; if (o_key !== 16'h0029) begin errors++; $display("FAIL glitch_next_key: got %h expected %h", o_key, 16'h0029); end
        checks++; if (err_cnt != 0) begin errors++; $display("FAIL glitch_next_err: got %0d pulses expected 0", err_cnt); end
    endtask

    task automatic test_pause();
        logic [7:0] seq [8];
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        clear_counts();
        for (int i = 0; i < 8; i++) send_byte(seq[i], 1'b0);
        checks++; if (vld_cnt != 1) begin errors++; $display("FAIL pause_vld: got %0d pulses expected 1", vld_cnt); end
        checks++; if (o_key !== 16'hE177) begin errors++; $display("FAIL pause_key: got %h expected %h", o_key, 16'hE177); end
        checks++; if (o_brk !== 1'b0) begin errors++; $display("FAIL pause_brk: got %b expected 0", o_brk); end
        checks++; if (err_cnt != 0) begin errors++; $display("FAIL pause_err: got %0d pulses expected 0", err_cnt); end
    endtask

    task automatic test_reset_mid_seq();
        logic [7:0] seq [8];
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        clear_counts();
        for (int i = 0; i < 3; i++) send_byte(seq[i], 1'b0);
        rst = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(2);
        checks++; if (o_key !== 16'h0000) begin errors++; $display("FAIL rst_mid_key: got %h expected %h", o_key, 16'h0000); end
        checks++; if ((o_brk !== 1'b0) || (o_vld !== 1'b0) || (o_err !== 1'b0)) begin errors++; $display("FAIL rst_mid_flags: got brk=%b vld=%b err=%b expected 0 0 0", o_brk, o_vld, o_err); end
        for (int i = 3; i < 8; i++) send_byte(seq[i], 1'b0);
        checks++; if (vld_cnt != 0) begin errors++; $display("FAIL rst_mid_vld: got %0d pulses expected 0", vld_cnt); end
        checks++; if (o_key !== 16'h0000) begin errors++; $display("FAIL rst_mid_final_key: got %h expected %h", o_key, 16'h0000); end
    endtask

    initial begin
        test_reset();
        test_make();
        test_break();
        test_extended();
        test_parity_err();
        test_drop();
        test_timeout();
        test_glitch();
        test_pause();
        test_reset_mid_seq();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
